free_list_ctrl: RTL
===================

FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_PREG, 64, physical register count; NUM_AREG, 32, architectural registers initially mapped to p0..p31; PW, 6, physical register tag width.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous and active-low.
REQ-004 alloc_req0, alloc_req1  in  1 each  rename slot 0 and slot 1 each request one destination tag.
REQ-005 alloc_gnt  out  1  allocation granted this cycle; all-or-nothing for the requesting slots.
REQ-006 alloc_preg0, alloc_preg1  out  PW each  tags for slot 0 and slot 1; valid only when alloc_gnt=1.
REQ-007 free_vld0, free_vld1  in  1 each  retire port valid.
REQ-008 free_preg0, free_preg1  in  PW each  tag being returned.
REQ-009 ckpt_save  in  1  snapshot the allocation head (branch rename).
REQ-010 ckpt_restore  in  1  roll the allocation head back to the snapshot (mispredict flush).
REQ-011 free_count  out  7  number of free tags currently held (0..64).
REQ-012 init_done  out  1  high once the list is populated.
REQ-013 err_overflow, err_p0  out  1 each  sticky error flags.

Function
REQ-014 Storage SHALL be a 64-entry circular buffer of PW-bit tags with 7-bit head and tail pointers (MSB = wrap bit); count = tail - head.
REQ-015 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-016 In INIT, one entry per cycle SHALL be written at tail with tag 32+k (k = 0..31), tail incrementing; after k=31 is written the FSM SHALL enter RUN on the next edge and assert init_done. INIT lasts exactly 32 cycles.
REQ-017 In INIT, alloc_gnt SHALL be 0, and free, ckpt_save and ckpt_restore SHALL be ignored.
REQ-018 nreq = alloc_req0 + alloc_req1; in RUN, alloc_gnt SHALL be asserted combinationally in the same cycle when nreq>0, count>=nreq and ckpt_restore=0.
REQ-019 Tag order: the lowest-numbered requesting slot SHALL receive entry[head] and the other requesting slot entry[head+1] (mod 64). Example: only req1 set gives alloc_preg1 = entry[head].
REQ-020 Head SHALL advance by nreq at the edge ending a granted cycle. No partial grant.
REQ-021 Availability SHALL use count before this cycle's frees; no same-cycle bypass from free to alloc.
REQ-022 Frees: each valid port SHALL write its tag at tail in port order (port 0 first), tail advancing by the number of accepted frees.
REQ-023 A free of tag 0 SHALL be dropped and SHALL set err_p0.
REQ-024 A free that would make count exceed 64 SHALL be dropped and SHALL set err_overflow; port 0 is evaluated before port 1.
REQ-025 ckpt_save SHALL capture head_next (post-allocation head this cycle) into ckpt_head.
REQ-026 ckpt_restore SHALL set head to ckpt_head, SHALL suppress allocation that cycle, and SHALL still accept that cycle's frees. When ckpt_save and ckpt_restore are both asserted, restore SHALL win and the save SHALL be ignored.
REQ-027 free_count SHALL equal tail - head as registered state, updated every edge: count_next = count - granted + accepted frees, or tail_next - ckpt_head on restore.
REQ-028 Pointer wrap from 63 to 0 SHALL toggle the wrap bit; full (64) and empty (0) SHALL be distinguished by the wrap bit.

Reset
REQ-029 When rst_n is asserted low, state SHALL be INIT; head, tail, init counter, ckpt_head and free_count SHALL be 0; alloc_gnt, init_done, err_overflow and err_p0 SHALL be 0; alloc_preg0/1 SHALL be 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL discard all contents and restart INIT after release.
REQ-031 The error flags SHALL clear only on reset.

Verification
REQ-032 Release reset, no requests for 32 cycles -> init_done=1 at cycle 32, free_count=32, entry[0]=32, entry[31]=63.
REQ-033 After init, req0=req1=1 each cycle for 16 cycles -> tags 32,33 then 34,35, ... 62,63; free_count=0; next cycle alloc_gnt=0.
REQ-034 free_count=1 with req0=req1=1 and free_vld0=1 (tag 40) in the same cycle -> alloc_gnt=0 and free_count=2 next cycle; grant the following cycle with tags {old head, 40}.
REQ-035 ckpt_save when head=4, then two grants of 2, then ckpt_restore with free_vld0=1 (tag 5) -> no grant that cycle, head=4, free_count = previous + 4 + 1.
REQ-036 free_count=64 and free_vld0=1 (tag 7) -> dropped, err_overflow=1, free_count stays 64. free_vld1=1 (tag 0) -> dropped, err_p0=1.
REQ-037 Drive 200 cycles of random alloc/free traffic crossing tail/head wrap, then assert rst_n low mid-traffic -> outputs reach reset values immediately, and INIT repeats correctly after release.

Source files
------------

// File: rtl/free_list_ctrl.sv
// Physical-register free list for a 2-wide renamer. After reset it is filled
// with the tags above the architectural range. The head pointer can be checkpointed.
module free_list_ctrl #(
  parameter int NUM_PREG = 64,
  parameter int NUM_AREG = 32,
  parameter int PW       = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_req0,
  input  logic          alloc_req1,
  output logic          alloc_gnt,
  output logic [PW-1:0] alloc_preg0,
  output logic [PW-1:0] alloc_preg1,
  input  logic          free_vld0,
  input  logic          free_vld1,
  input  logic [PW-1:0] free_preg0,
  input  logic [PW-1:0] free_preg1,
  input  logic          ckpt_save,
  input  logic          ckpt_restore,
  output logic [PW:0]   free_count,
  output logic          init_done,
  output logic          err_overflow,
  output logic          err_p0
);

  localparam int                IW        = $clog2(NUM_PREG - NUM_AREG);
  localparam logic [IW-1:0]     INIT_LAST = IW'(NUM_PREG - NUM_AREG - 1);
  localparam logic [PW:0]       CAP       = (PW+1)'(NUM_PREG);
  localparam logic [PW-1:0]     INIT_BASE = PW'(NUM_AREG);
  localparam logic [PW-1:0]     TAG_ZERO  = {PW{1'b0}};
  localparam logic [PW:0]       PTR_ZERO  = {(PW+1){1'b0}};
  localparam logic [PW:0]       PTR_ONE   = {{PW{1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_r, state_next_s;
  logic [PW-1:0] entry_r [NUM_PREG];
  logic [PW:0]   head_r, head_next_s;
  logic [PW:0]   tail_r, tail_next_s;
  logic [PW:0]   ckpt_head_r, ckpt_head_next_s;
  logic [PW:0]   free_count_r, count_next_s;
  logic [IW-1:0] init_cnt_r, init_cnt_next_s;
  logic          init_done_r;
  logic          err_overflow_r;
  logic          err_p0_r;

  logic          run_s;
  logic [1:0]    nreq_s;
  logic [PW:0]   nreq_ext_s;
  logic          gnt_s;
  logic [PW:0]   alloc_n_s;
  logic [PW:0]   head_adv_s;
  logic [PW-1:0] head_idx0_s, head_idx1_s;
  logic [PW-1:0] preg0_s, preg1_s;
  logic [PW:0]   base0_s, base1_s;
  logic          zero0_s, zero1_s;
  logic          room0_s, room1_s;
  logic          acc0_s, acc1_s;
  logic          ovf_s, p0_s;
  logic [PW-1:0] tail_idx0_s, tail_idx1_s;

  assign run_s = (state_r == ST_RUN);

  // Allocation grant and tag selection; availability uses the registered count only.
  always_comb begin
    nreq_s      = {1'b0, alloc_req0} + {1'b0, alloc_req1};
    nreq_ext_s  = {{(PW-1){1'b0}}, nreq_s};
    gnt_s       = run_s && (nreq_s != 2'd0) && (free_count_r >= nreq_ext_s) && !ckpt_restore;
    alloc_n_s   = gnt_s ? nreq_ext_s : PTR_ZERO;
    head_adv_s  = head_r + alloc_n_s;
    head_idx0_s = head_r[PW-1:0];
    head_idx1_s = head_idx0_s + {{(PW-1){1'b0}}, 1'b1};
    preg0_s     = TAG_ZERO;
    preg1_s     = TAG_ZERO;
    if (gnt_s && alloc_req0) begin
      preg0_s = entry_r[head_idx0_s];
      preg1_s = alloc_req1 ? entry_r[head_idx1_s] : TAG_ZERO;
    end else if (gnt_s && alloc_req1) begin
      preg1_s = entry_r[head_idx0_s];
    end else begin
      preg0_s = TAG_ZERO;
    end
  end

  // Free acceptance: on restore the entries between ckpt_head and head come back,
  // so capacity is measured from the checkpoint instead of the post-grant head.
  always_comb begin
    base0_s     = ckpt_restore ? (tail_r - ckpt_head_r) : (free_count_r - alloc_n_s);
    zero0_s     = (free_preg0 == TAG_ZERO);
    zero1_s     = (free_preg1 == TAG_ZERO);
    room0_s     = (base0_s < CAP);
    acc0_s      = run_s && free_vld0 && !zero0_s && room0_s;
    base1_s     = base0_s + {{PW{1'b0}}, acc0_s};
    room1_s     = (base1_s < CAP);
    acc1_s      = run_s && free_vld1 && !zero1_s && room1_s;
    ovf_s       = run_s && ((free_vld0 && !zero0_s && !room0_s) ||
                            (free_vld1 && !zero1_s && !room1_s));
    p0_s        = run_s && ((free_vld0 && zero0_s) || (free_vld1 && zero1_s));
    tail_idx0_s = tail_r[PW-1:0];
    tail_idx1_s = tail_idx0_s + {{(PW-1){1'b0}}, acc0_s};
  end

  // Next-state and pointer update logic for the INIT/RUN FSM.
  always_comb begin
    state_next_s     = state_r;
    init_cnt_next_s  = init_cnt_r;
    head_next_s      = head_r;
    tail_next_s      = tail_r;
    ckpt_head_next_s = ckpt_head_r;
    case (state_r)
      ST_INIT: begin
        tail_next_s     = tail_r + PTR_ONE;
        init_cnt_next_s = init_cnt_r + {{(IW-1){1'b0}}, 1'b1};
        if (init_cnt_r == INIT_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN: begin
        tail_next_s = tail_r + {{PW{1'b0}}, acc0_s} + {{PW{1'b0}}, acc1_s};
        if (ckpt_restore) begin
          head_next_s = ckpt_head_r;
        end else begin
          head_next_s = head_adv_s;
          if (ckpt_save) begin
            ckpt_head_next_s = head_adv_s;
          end else begin
            ckpt_head_next_s = ckpt_head_r;
          end
        end
      end
      default: begin
        state_next_s = ST_INIT;
      end
    endcase
    count_next_s = tail_next_s - head_next_s;
  end

  // Control state, pointers, count and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_INIT;
      head_r         <= PTR_ZERO;
      tail_r         <= PTR_ZERO;
      ckpt_head_r    <= PTR_ZERO;
      free_count_r   <= PTR_ZERO;
      init_cnt_r     <= {IW{1'b0}};
      init_done_r    <= 1'b0;
      err_overflow_r <= 1'b0;
      err_p0_r       <= 1'b0;
    end else begin
      state_r        <= state_next_s;
      head_r         <= head_next_s;
      tail_r         <= tail_next_s;
      ckpt_head_r    <= ckpt_head_next_s;
      free_count_r   <= count_next_s;
      init_cnt_r     <= init_cnt_next_s;
      init_done_r    <= (state_next_s == ST_RUN);
      err_overflow_r <= err_overflow_r | ovf_s;
      err_p0_r       <= err_p0_r | p0_s;
    end
  end

  // Tag storage; contents are rebuilt by INIT after every reset.
  always_ff @(posedge clk) begin
    if (!run_s) begin
      entry_r[tail_idx0_s] <= INIT_BASE + PW'(init_cnt_r);
    end else begin
      if (acc0_s) begin
        entry_r[tail_idx0_s] <= free_preg0;
      end
      if (acc1_s) begin
        entry_r[tail_idx1_s] <= free_preg1;
      end
    end
  end

  assign alloc_gnt    = gnt_s;
  assign alloc_preg0  = preg0_s;
  assign alloc_preg1  = preg1_s;
  assign free_count   = free_count_r;
  assign init_done    = init_done_r;
  assign err_overflow = err_overflow_r;
  assign err_p0       = err_p0_r;

endmodule
